// File: rtl/upe_add16_core.sv
// rtl/upe_add16_core.sv - value/uncertainty pair adder with registered results
// Value path wraps; uncertainty path clamps to all-ones on overflow.

module upe_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module upe_ripple_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            upe_full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry[i]),
                .sum  (sum[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    assign cout = carry[WIDTH];
endmodule

module upe_add16_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic             carry_out,
    output logic             unc_sat,
    output logic             out_valid
);
    logic [WIDTH-1:0] val_sum;
    logic             val_carry;
    logic [WIDTH-1:0] unc_sum;
    logic             unc_carry;
    logic [WIDTH-1:0] unc_clamped;

    upe_ripple_add #(.WIDTH(WIDTH)) u_val_add (
        .a    (A),
        .b    (C),
        .cin  (1'b0),
        .sum  (val_sum),
        .cout (val_carry)
    );

    upe_ripple_add #(.WIDTH(WIDTH)) u_unc_add (
        .a    (B),
        .b    (D),
        .cin  (1'b0),
        .sum  (unc_sum),
        .cout (unc_carry)
    );

    // Worst-case uncertainty must never shrink by wrapping, so pin it at full scale.
    assign unc_clamped = unc_carry ? {WIDTH{1'b1}} : unc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out1      <= '0;
            Out2      <= '0;
            carry_out <= 1'b0;
            unc_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out1      <= val_sum;
                carry_out <= val_carry;
                Out2      <= unc_clamped;
                unc_sat   <= unc_carry;
            end
        end
    end
endmodule

// File: tb/tb_upe_add16_core.sv
// tb/tb_upe_add16_core.sv - directed-vector bench for upe_add16_core

module tb_upe_add16_core;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A, B, C, D;
    logic [15:0] Out1, Out2;
    logic        carry_out, unc_sat, out_valid;

    int checks;
    int errors;

    logic [34:0] got;
    logic [34:0] exp_v;

    upe_add16_core #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .Out1      (Out1),
        .Out2      (Out2),
        .carry_out (carry_out),
        .unc_sat   (unc_sat),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {Out1, Out2, carry_out, unc_sat, out_valid}
    assign got = {Out1, Out2, carry_out, unc_sat, out_valid};

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] vc [8];
    logic [15:0] vd [8];
    logic [34:0] ve [8];

    initial begin
        va[0] = 16'h1234; vb[0] = 16'h0001; vc[0] = 16'h4321; vd[0] = 16'h0002; ve[0] = {16'h5555, 16'h0003, 3'b001};
        va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 16'h8000; vd[1] = 16'h8000; ve[1] = {16'h0000, 16'hFFFF, 3'b111};
        va[2] = 16'hAAAA; vb[2] = 16'h5555; vc[2] = 16'h5555; vd[2] = 16'hAAAA; ve[2] = {16'hFFFF, 16'hFFFF, 3'b001};
        va[3] = 16'hAAAB; vb[3] = 16'h5556; vc[3] = 16'h5555; vd[3] = 16'hAAAA; ve[3] = {16'h0000, 16'hFFFF, 3'b111};
        va[4] = 16'h00FF; vb[4] = 16'h0F0F; vc[4] = 16'h0F01; vd[4] = 16'h00F1; ve[4] = {16'h1000, 16'h1000, 3'b001};
        va[5] = 16'hFFFE; vb[5] = 16'hFFFE; vc[5] = 16'h0001; vd[5] = 16'h0001; ve[5] = {16'hFFFF, 16'hFFFF, 3'b001};
        va[6] = 16'h1111; vb[6] = 16'h2222; vc[6] = 16'h3333; vd[6] = 16'h4444; ve[6] = {16'h4444, 16'h6666, 3'b001};
        va[7] = 16'hF000; vb[7] = 16'h9000; vc[7] = 16'h1234; vd[7] = 16'h7123; ve[7] = {16'h0234, 16'hFFFF, 3'b111};
    end

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A = 16'hDEAD; B = 16'hBEEF; C = 16'hFFFF; D = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        exp_v = '0;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", got, exp_v);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_nominal;
        @(negedge clk);
        A = 16'h6751; B = 16'h0B12; C = 16'hCD84; D = 16'h0A1F; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_v = {16'h34D5, 16'h1531, 3'b101};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL nominal got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        A = 16'h7F7D; B = 16'hF7D8; C = 16'hFFFF; D = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_v = {16'h7F7C, 16'hFFFF, 3'b111};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL saturation got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_boundary;
        @(negedge clk);
        A = 16'hFFFF; B = 16'h8000; C = 16'h0001; D = 16'h7FFF; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_v = {16'h0000, 16'hFFFF, 3'b101};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL boundary_max got=%h exp=%h", got, exp_v);
        end
        @(negedge clk);
        A = 16'h0000; B = 16'h0000; C = 16'h0000; D = 16'h0000; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_v = {16'h0000, 16'h0000, 3'b001};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL boundary_zero got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; C = 16'h3333; D = 16'h4444; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_v = {16'h4444, 16'h6666, 3'b001};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL hold_pulse got=%h exp=%h", got, exp_v);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = 16'hFFFF - 16'(k); B = 16'hFFFF; C = 16'h00F0 + 16'(k); D = 16'hFFFF;
            @(posedge clk); #1;
            exp_v = {16'h4444, 16'h6666, 3'b000};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL hold_idle%0d got=%h exp=%h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        A = 16'h6751; B = 16'h0B12; C = 16'hCD84; D = 16'h0A1F; in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = '0;
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", got, exp_v);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                rst_n = 1'b0;
                #1;
                exp_v = '0;
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL stream_reset_now got=%h exp=%h", got, exp_v);
                end
                @(posedge clk); #1;
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL stream_reset_edge got=%h exp=%h", got, exp_v);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            A = va[i]; B = vb[i]; C = vc[i]; D = vd[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            exp_v = ve[i];
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL stream%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_v = {ve[7][34:3], 3'b110};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL stream_tail got=%h exp=%h", got, exp_v);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A = '0; B = '0; C = '0; D = '0;
        #1;
        test_reset;
        test_nominal;
        test_saturation;
        test_boundary;
        test_hold;
        test_async_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
